// File: rtl/writeback_regfile.sv
// Writeback register file: 2^ADDR_WIDTH general purpose registers plus HI/LO.
// Two combinational read ports with same-cycle write bypass; register 0 is
// hardwired to zero. All storage clears asynchronously on reset.
module writeback_regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] wb_write_reg_address_input,
  input  logic                  wb_write_reg_enable_input,
  input  logic [DATA_WIDTH-1:0] wb_write_reg_data_input,
  input  logic [DATA_WIDTH-1:0] wb_hi_input,
  input  logic [DATA_WIDTH-1:0] wb_lo_input,
  input  logic                  wb_whilo_input,
  input  logic                  read1_enable_input,
  input  logic [ADDR_WIDTH-1:0] read1_address_input,
  output logic [DATA_WIDTH-1:0] read1_data_output,
  input  logic                  read2_enable_input,
  input  logic [ADDR_WIDTH-1:0] read2_address_input,
  output logic [DATA_WIDTH-1:0] read2_data_output,
  output logic [DATA_WIDTH-1:0] hi_output,
  output logic [DATA_WIDTH-1:0] lo_output
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] gpr_q [NumRegs];
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;

  // Writes to address 0 are dropped so entry 0 stays at its reset value.
  logic gpr_write;
  assign gpr_write = wb_write_reg_enable_input && (wb_write_reg_address_input != '0);

  // GPR storage: async clear, write on posedge when addressed register is nonzero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gpr_q <= '{default: '0};
    end else if (gpr_write) begin
      gpr_q[wb_write_reg_address_input] <= wb_write_reg_data_input;
    end
  end

  // HI/LO storage: updated together, independent of the GPR write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb_whilo_input) begin
      hi_q <= wb_hi_input;
      lo_q <= wb_lo_input;
    end
  end

  // Read port 1: priority select with same-cycle bypass of the pending write.
  always_comb begin
    read1_data_output = '0;
    if (reset || !read1_enable_input || (read1_address_input == '0)) begin
      read1_data_output = '0;
    end else if (gpr_write && (read1_address_input == wb_write_reg_address_input)) begin
      read1_data_output = wb_write_reg_data_input;
    end else begin
      read1_data_output = gpr_q[read1_address_input];
    end
  end

  // Read port 2: identical selection to port 1.
  always_comb begin
    read2_data_output = '0;
    if (reset || !read2_enable_input || (read2_address_input == '0)) begin
      read2_data_output = '0;
    end else if (gpr_write && (read2_address_input == wb_write_reg_address_input)) begin
      read2_data_output = wb_write_reg_data_input;
    end else begin
      read2_data_output = gpr_q[read2_address_input];
    end
  end

  // HI/LO are presented straight from storage with no bypass.
  assign hi_output = hi_q;
  assign lo_output = lo_q;

endmodule
